data_memory_unit: RTL and testbench

//  Data-memory stage consuming the M-stage bus (ALUResultM, WriteDataM, MemWriteM, funct3M) and producing ReadDataM.

---
 rtl/dmem_pkg.sv | 46 ++++
 rtl/uart_tx_fsm.sv | 99 +++++++++
 rtl/data_memory_unit.sv | 155 +++++++++++++++
 tb/tb_data_memory_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory stage: access sizes, MMIO register
// offsets, UART FSM states and the address-region decoder.
package dmem_pkg;

    typedef enum logic [2:0] {
        SizeByte = 3'b000,
        SizeHalf = 3'b001,
        SizeWord = 3'b010
    } mem_size_e;

    // Byte offsets within the 4 KiB MMIO page
    localparam logic [11:0] OffLed      = 12'h000;
    localparam logic [11:0] OffSw       = 12'h004;
    localparam logic [11:0] OffCycleLo  = 12'h008;
    localparam logic [11:0] OffCycleHi  = 12'h00C;
    localparam logic [11:0] OffUartTx   = 12'h010;
    localparam logic [11:0] OffUartStat = 12'h014;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        RegionRam,
        RegionMmio,
        RegionNone
    } region_e;

    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] mmio_base);
        region_e region;
        if (addr < ram_bytes) begin
            region = RegionRam;
        end else if (addr[31:12] == mmio_base[31:12]) begin
            region = RegionMmio;
        end else begin
            region = RegionNone;
        end
        return region;
    endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// 8N1 UART transmitter: a start pulse latches one byte and sends start, 8 data bits
// LSB-first and stop, each held for CLKS_PER_BIT clocks.
module uart_tx_fsm
    import dmem_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    uart_state_t     state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            baud_last;

    assign baud_last = (baud_q == CntMax);
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    shreg_d = data;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so tx never glitches
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/data_memory_unit.sv
// M-stage data memory: word RAM with byte/half/word stores plus an MMIO page (LEDs,
// switches, 64-bit cycle counter, UART). Define DMEM_UART_EN to build the UART.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE    = 32'h1000_0000,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        uart_tx,
    output logic        misalignM
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RamBytes = 32'(DEPTH_WORDS * 4);

    logic [31:0]     mem_q [DEPTH_WORDS];
    region_e         region;
    logic [IdxW-1:0] ram_idx;
    logic [11:0]     mmio_off;
    logic            is_byte, is_half, is_word;
    logic            store_ok, ram_we, mmio_we;
    logic [3:0]      lane_be;
    logic [31:0]     lane_data;
    logic [15:0]     led_q, led_d;
    logic [63:0]     cycle_q, cycle_d;
    logic            uart_busy, uart_overrun;

    assign region   = decode_region(ALUResultM, RamBytes, MMIO_BASE);
    assign ram_idx  = ALUResultM[IdxW+1:2];
    // Registers are word-decoded, so byte/half stores land on the containing register
    assign mmio_off = {ALUResultM[11:2], 2'b00};
    assign led      = led_q;

    always_comb begin
        is_byte   = (funct3M == SizeByte);
        is_half   = (funct3M == SizeHalf);
        is_word   = (funct3M == SizeWord);
        misalignM = MemWriteM & ((is_half & ALUResultM[0]) | (is_word & (|ALUResultM[1:0])));
        store_ok  = MemWriteM & (is_byte | is_half | is_word) & ~misalignM;
        ram_we    = store_ok & (region == RegionRam);
        mmio_we   = store_ok & (region == RegionMmio);

        lane_be   = 4'b0000;
        lane_data = WriteDataM;
        if (is_byte) begin
            lane_be   = 4'b0001 << ALUResultM[1:0];
            lane_data = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            lane_be   = ALUResultM[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{WriteDataM[15:0]}};
        end else if (is_word) begin
            lane_be   = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) begin
                    mem_q[ram_idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 64'd1;
        if (mmio_we && (mmio_off == OffLed)) begin
            led_d = WriteDataM[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= '0;
            cycle_q <= '0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
        end
    end

`ifdef DMEM_UART_EN
    logic uart_start, overrun_q, overrun_d, tx_hit, stat_hit;

    assign tx_hit       = mmio_we && (mmio_off == OffUartTx);
    assign stat_hit     = mmio_we && (mmio_off == OffUartStat);
    assign uart_start   = tx_hit && !uart_busy;
    assign uart_overrun = overrun_q;

    // Set is applied after clear so a simultaneous overrun event wins
    always_comb begin
        overrun_d = overrun_q;
        if (stat_hit) begin
            overrun_d = 1'b0;
        end
        if (tx_hit && uart_busy) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    uart_tx_fsm #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_fsm (
        .clk  (clk),
        .rst  (rst),
        .start(uart_start),
        .data (WriteDataM[7:0]),
        .busy (uart_busy),
        .tx   (uart_tx)
    );
`else
    assign uart_busy    = 1'b0;
    assign uart_overrun = 1'b0;
    assign uart_tx      = 1'b1;
`endif

    always_comb begin
        ReadDataM = '0;
        case (region)
            RegionRam: ReadDataM = mem_q[ram_idx];
            RegionMmio: begin
                case (mmio_off)
                    OffLed:      ReadDataM = {16'b0, led_q};
                    OffSw:       ReadDataM = {16'b0, sw};
                    OffCycleLo:  ReadDataM = cycle_q[31:0];
                    OffCycleHi:  ReadDataM = cycle_q[63:32];
                    OffUartStat: ReadDataM = {30'b0, uart_overrun, uart_busy};
                    default:     ReadDataM = '0;
                endcase
            end
            default: ReadDataM = '0;
        endcase
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit with a byte-level reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_data_memory_unit;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [15:0] sw;
    logic [15:0] led;
    logic        uart_tx;
    logic        misalignM;

    int n_cmp = 0;
    int n_err = 0;

    data_memory_unit #(
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (32'h1000_0000),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWriteM (MemWriteM),
        .funct3M   (funct3M),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .ReadDataM (ReadDataM),
        .sw        (sw),
        .led       (led),
        .uart_tx   (uart_tx),
        .misalignM (misalignM)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]      ram_m [int];
    logic [15:0]     led_m;
    longint unsigned cycle_m;
    bit              overrun_m;
    bit              txq [$];
    bit              model_valid = 1'b0;

    function automatic bit uart_en();
`ifdef DMEM_UART_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_misaligned(logic we, logic [2:0] f3, logic [31:0] a);
        return we && ((f3 == 3'd1 && (a % 2) != 0) || (f3 == 3'd2 && (a % 4) != 0));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          busy_pre;
        logic [31:0] a;
        logic [31:0] off;
        int          nbytes;
        if (rst) begin
            led_m     = '0;
            cycle_m   = 0;
            overrun_m = 1'b0;
            txq.delete();
            model_valid = 1'b1;
        end else begin
            busy_pre = (txq.size() != 0);
            cycle_m++;
            if (txq.size() != 0) void'(txq.pop_front());
            a = ALUResultM;
            if (MemWriteM && funct3M <= 3'd2 && !is_misaligned(MemWriteM, funct3M, a)) begin
                if (a < 32'd4096) begin
                    nbytes = 1 << funct3M;
                    for (int i = 0; i < nbytes; i++) ram_m[int'(a) + i] = WriteDataM[8*i +: 8];
                end else if (a[31:12] == 20'h10000) begin
                    off = a & 32'h0000_0FFC;
                    if (off == 32'h0) begin
                        led_m = WriteDataM[15:0];
                    end else if (off == 32'h10 && uart_en()) begin
                        if (busy_pre) begin
                            overrun_m = 1'b1;
                        end else begin
                            for (int i = 0; i < 10 * CPB; i++) begin
                                int s;
                                s = i / CPB;
                                txq.push_back(s == 0 ? 1'b0 : s == 9 ? 1'b1 : WriteDataM[s-1]);
                            end
                        end
                    end else if (off == 32'h14 && uart_en()) begin
                        overrun_m = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic expect_read(output bit known, output logic [31:0] v);
        logic [31:0] a;
        logic [31:0] off;
        int          w;
        a     = ALUResultM;
        v     = '0;
        known = 1'b1;
        if (a < 32'd4096) begin
            w = int'(a) & ~3;
            for (int i = 0; i < 4; i++) begin
                if (!ram_m.exists(w + i)) known = 1'b0;
                else v[8*i +: 8] = ram_m[w + i];
            end
        end else if (a[31:12] == 20'h10000) begin
            off = a & 32'h0000_0FFC;
            if (off == 32'h0)       v = {16'b0, led_m};
            else if (off == 32'h4)  v = {16'b0, sw};
            else if (off == 32'h8)  v = cycle_m[31:0];
            else if (off == 32'hC)  v = cycle_m[63:32];
            else if (off == 32'h14) v = uart_en() ? {30'b0, overrun_m, txq.size() != 0} : 32'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        bit          known;
        logic [31:0] v;
        @(negedge clk);
        if (model_valid) begin
            check("model_misalign", {63'b0, misalignM},
                  {63'b0, is_misaligned(MemWriteM, funct3M, ALUResultM)});
            check("model_led", {48'b0, led}, {48'b0, led_m});
            check("model_uart_tx", {63'b0, uart_tx}, {63'b0, txq.size() != 0 ? txq[0] : 1'b1});
            expect_read(known, v);
            if (known) check("model_rdata", {32'b0, ReadDataM}, {32'b0, v});
        end
    end

    task automatic set_in(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
        MemWriteM  = we;
        funct3M    = f3;
        ALUResultM = a;
        WriteDataM = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        set_in(1'b0, 3'd2, a, 32'h0);
        @(negedge clk);
        check(name, {32'b0, ReadDataM}, {32'b0, exp});
        step();
    endtask

    initial begin
        logic [9:0] frame55;
        frame55 = {1'b1, 8'h55, 1'b0};
        sw  = 16'hBEEF;
        rst = 1'b1;
        set_in(1'b0, 3'd2, 32'h1000_0008, 32'h0);
        step();
        step();
        rst = 1'b0;

        // Cycle counter: ten non-reset edges
        repeat (10) step();
        @(negedge clk);
        check("cycle_lo_10", {32'b0, ReadDataM}, 64'd10);
        set_in(1'b0, 3'd2, 32'h1000_000C, 32'h0);
        #1;
        check("cycle_hi_0", {32'b0, ReadDataM}, 64'd0);
        step();

        // RAM stores and masking
        set_in(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF);
        step();
        read_check("sw_word", 32'h8, 32'hDEAD_BEEF);
        set_in(1'b1, 3'd0, 32'h9, 32'h0000_00AA);
        step();
        read_check("sb_lane1", 32'h8, 32'hDEAD_AAEF);
        set_in(1'b1, 3'd1, 32'hA, 32'h0000_1234);
        step();
        read_check("sh_upper", 32'h8, 32'h1234_AAEF);

        set_in(1'b1, 3'd1, 32'hB, 32'h0000_FFFF);
        @(negedge clk);
        check("misalign_sh", {63'b0, misalignM}, 64'd1);
        step();
        read_check("sh_misaligned_nowrite", 32'h8, 32'h1234_AAEF);

        set_in(1'b1, 3'd2, 32'h4, 32'h1122_3344);
        step();
        set_in(1'b1, 3'd2, 32'h6, 32'hFFFF_FFFF);
        @(negedge clk);
        check("misalign_sw", {63'b0, misalignM}, 64'd1);
        step();
        read_check("sw_misaligned_nowrite", 32'h4, 32'h1122_3344);

        set_in(1'b1, 3'd3, 32'h8, 32'h0);
        @(negedge clk);
        check("f3_other_no_misalign", {63'b0, misalignM}, 64'd0);
        step();
        read_check("f3_other_nowrite", 32'h8, 32'h1234_AAEF);

        set_in(1'b1, 3'd2, 32'h2000, 32'hFFFF_FFFF);
        step();
        read_check("unmapped_read0", 32'h2000, 32'h0);

        set_in(1'b1, 3'd2, 32'h8, 32'hCAFE_F00D);
        @(negedge clk);
        check("no_bypass", {32'b0, ReadDataM}, {32'b0, 32'h1234_AAEF});
        step();
        read_check("after_write", 32'h8, 32'hCAFE_F00D);

        // MMIO registers
        set_in(1'b1, 3'd2, 32'h1000_0000, 32'hFFFF_A5A5);
        step();
        @(negedge clk);
        check("led_a5a5", {48'b0, led}, 64'h0000_0000_0000_A5A5);
        step();
        read_check("led_read", 32'h1000_0000, 32'h0000_A5A5);
        set_in(1'b1, 3'd0, 32'h1000_0001, 32'h0000_005A);
        step();
        @(negedge clk);
        check("led_sb_as_sw", {48'b0, led}, 64'h5A);
        step();
        read_check("sw_read", 32'h1000_0004, 32'h0000_BEEF);
        set_in(1'b1, 3'd2, 32'h1000_0018, 32'hFFFF_FFFF);
        step();
        read_check("unused_off", 32'h1000_0018, 32'h0);

`ifdef DMEM_UART_EN
        set_in(1'b1, 3'd2, 32'h1000_0010, 32'h55);
        step();
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k == 5) set_in(1'b1, 3'd2, 32'h1000_0010, 32'hFF);
            else        set_in(1'b0, 3'd2, 32'h1000_0014, 32'h0);
            @(negedge clk);
            check("frame55_tx", {63'b0, uart_tx}, {63'b0, frame55[k/CPB]});
            if (k != 5) check("stat_in_frame", {32'b0, ReadDataM}, k < 5 ? 64'd1 : 64'd3);
            step();
        end
        set_in(1'b0, 3'd2, 32'h1000_0014, 32'h0);
        @(negedge clk);
        check("tx_idle_after", {63'b0, uart_tx}, 64'd1);
        check("stat_overrun_only", {32'b0, ReadDataM}, 64'd2);
        step();
        set_in(1'b1, 3'd0, 32'h1000_0014, 32'h0);
        step();
        read_check("stat_cleared", 32'h1000_0014, 32'h0);

        set_in(1'b1, 3'd2, 32'h1000_0010, 32'h0F);
        step();
        set_in(1'b0, 3'd2, 32'h1000_0014, 32'h0);
        repeat (10) step();
        @(negedge clk);
        check("busy_mid_frame", {32'b0, ReadDataM}, 64'd1);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_tx_idle", {63'b0, uart_tx}, 64'd1);
        check("rst_stat_0", {32'b0, ReadDataM}, 64'd0);
        step();
        rst = 1'b0;
`else
        set_in(1'b1, 3'd2, 32'h1000_0010, 32'h55);
        step();
        set_in(1'b0, 3'd2, 32'h1000_0014, 32'h0);
        @(negedge clk);
        check("nouart_tx_high", {63'b0, uart_tx}, 64'd1);
        check("nouart_stat_0", {32'b0, ReadDataM}, 64'd0);
        step();
`endif

        set_in(1'b1, 3'd2, 32'h1000_0000, 32'h0000_1111);
        step();
        set_in(1'b0, 3'd2, 32'h1000_0008, 32'h0);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_led_0", {48'b0, led}, 64'd0);
        check("rst_cycle_0", {32'b0, ReadDataM}, 64'd0);
        step();
        rst = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
